// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one word fetch, holds the returned word
// until the decoder accepts it, then advances the PC or takes the redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    input  logic        inst_ready,
    input  logic        pc_write,
    input  logic [31:0] next_pc,
    input  logic        halt,
    output logic        is_halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED} state_e;

    state_e      state_q;
    logic [31:0] pc_q, inst_q, inst_pc_q, count_q;
    logic        req_q, valid_q, halted_q;
    logic [31:0] pc_d;
    logic        accept;
    logic        unused_next_pc_lsb;

    assign accept             = valid_q & inst_ready;
    assign pc_d               = pc_write ? {next_pc[31:2], 2'b00} : pc_q + 32'd4;
    assign unused_next_pc_lsb = ^next_pc[1:0];

    // req_q is low for the first cycle out of reset, so a response left over
    // from before reset is never mistaken for one to the new request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (req_q && imem_rsp_valid) begin
                        inst_q    <= imem_rdata;
                        inst_pc_q <= pc_q;
                        req_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_HOLD;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        count_q <= count_q + 32'd1;
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        if (halt) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                            req_q    <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_HALTED: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign opcode      = inst_q[6:0];
    assign is_halted   = halted_q;
    assign fetch_count = count_q;

endmodule
